// File: rtl/ov_sccb_slave.sv
// SCCB (OmniVision camera bus) register slave, oversampled on clk.
// Optional OV_SCCB_SLAVE_SOFT_RESET_EN: writing 0x12 with bit7 set clears all registers.
module ov_sccb_slave #(
  parameter logic [7:0] CHIP_ADDR = 8'h42,
  parameter logic [7:0] PID_VAL   = 8'h76,
  parameter logic [7:0] VER_VAL   = 8'h73
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sio_c,
  inout  wire        sio_d,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE
  } state_t;

  state_t     state, state_n;
  logic       scl_m, scl_s, scl_q;
  logic       sda_m, sda_s, sda_q;
  logic       scl_rise, scl_fall;
  logic       start_c, stop_c;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic [7:0] tx, tx_n;
  logic [7:0] sub_addr, sub_n;
  logic [7:0] rd_val;
  logic       rw, rw_n;
  logic       oe, oe_n;
  logic       commit, we;
  logic [7:0] regs [256];

  // open-drain pad: only ever pull low
  assign sio_d = oe ? 1'b0 : 1'bz;

  // two-flop synchronizers plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_q <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_m <= sio_c;
      scl_s <= scl_m;
      scl_q <= scl_s;
      sda_m <= sio_d;
      sda_s <= sda_m;
      sda_q <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start_c  = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_c   = scl_s & scl_q & ~sda_q & sda_s;

  // read mux with the fixed ID registers overlaid
  always_comb begin
    unique case (1'b1)
      (sub_addr == 8'h0A): rd_val = PID_VAL;
      (sub_addr == 8'h0B): rd_val = VER_VAL;
      default:             rd_val = regs[sub_addr];
    endcase
  end

  // bus protocol: shift on SCL rise, change drive on SCL fall
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    tx_n    = tx;
    rw_n    = rw;
    oe_n    = oe;
    sub_n   = sub_addr;
    commit  = 1'b0;
    if (start_c) begin
      state_n = ID;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else if (stop_c) begin
      state_n = IDLE;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else begin
      unique case (state)
        ID: begin
          if (scl_rise) begin
            sh_n  = {sh[6:0], sda_s};
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_n = '0;
            if (sh[7:1] == CHIP_ADDR[7:1]) begin
              state_n = ID_ACK;
              oe_n    = 1'b1;
              rw_n    = sh[0];
            end else begin
              state_n = IGNORE;
            end
          end
        end
        ID_ACK: begin
          if (scl_fall) begin
            cnt_n = '0;
            if (rw) begin
              state_n = RDATA;
              oe_n    = ~rd_val[7];
              tx_n    = {rd_val[6:0], 1'b0};
            end else begin
              state_n = SUB;
              oe_n    = 1'b0;
            end
          end
        end
        SUB: begin
          if (scl_rise) begin
            sh_n  = {sh[6:0], sda_s};
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = SUB_ACK;
            cnt_n   = '0;
            oe_n    = 1'b1;
            sub_n   = sh;
          end
        end
        SUB_ACK: begin
          if (scl_fall) begin
            state_n = WDATA;
            oe_n    = 1'b0;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            sh_n  = {sh[6:0], sda_s};
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = WDATA_ACK;
            cnt_n   = '0;
            oe_n    = 1'b1;
            commit  = 1'b1;
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            state_n = IGNORE;
            oe_n    = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              state_n = RDATA_NA;
              cnt_n   = '0;
              oe_n    = 1'b0;
            end else begin
              oe_n = ~tx[7];
              tx_n = {tx[6:0], 1'b0};
            end
          end
        end
        RDATA_NA: begin
          if (scl_fall) begin
            state_n = IGNORE;
          end
        end
        default: begin
          oe_n = 1'b0;
        end
      endcase
    end
  end

  // protocol state and write-port registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      tx        <= '0;
      rw        <= 1'b0;
      oe        <= 1'b0;
      sub_addr  <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      tx        <= tx_n;
      rw        <= rw_n;
      oe        <= oe_n;
      sub_addr  <= sub_n;
      wr_strobe <= commit;
      if (commit) begin
        wr_addr <= sub_addr;
        wr_data <= sh;
      end
    end
  end

  assign we = commit && sub_addr != 8'h0A && sub_addr != 8'h0B;

`ifdef OV_SCCB_SLAVE_SOFT_RESET_EN
  logic       sweep;
  logic [7:0] sweep_idx;

  // 256-cycle clear sweep launched by 0x12[7]
  always_ff @(posedge clk) begin
    if (reset) begin
      sweep     <= 1'b0;
      sweep_idx <= '0;
    end else if (sweep) begin
      sweep_idx <= sweep_idx + 8'd1;
      if (sweep_idx == 8'hFF) sweep <= 1'b0;
    end else if (commit && sub_addr == 8'h12 && sh[7]) begin
      sweep     <= 1'b1;
      sweep_idx <= '0;
    end
  end

  // register file; the sweep wins over bus writes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) regs[i] <= '0;
    end else if (sweep) begin
      regs[sweep_idx] <= '0;
    end else if (we) begin
      regs[sub_addr] <= sh;
    end
  end

  assign busy = (state != IDLE) | sweep;
`else
  // register file
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) regs[i] <= '0;
    end else if (we) begin
      regs[sub_addr] <= sh;
    end
  end

  assign busy = (state != IDLE);
`endif

endmodule

// File: doc/ov_sccb_slave.md
OV_SCCB_SLAVE -- requirements
Module: ov_sccb_slave

Interface
REQ-001 SHALL have parameter CHIP_ADDR, default 8'h42, giving the 7-bit SCCB device ID in bits [7:1]; bit 0 is ignored.
REQ-002 SHALL have parameter PID_VAL, default 8'h76, giving the read-only value of register 0x0A.
REQ-003 SHALL have parameter VER_VAL, default 8'h73, giving the read-only value of register 0x0B.
REQ-004 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sio_c  input  1  SCCB clock driven by the master; asynchronous to clk.
REQ-007 SHALL have port sio_d  inout  1  SCCB data, open-drain: driven 0 when the slave drives low, high-Z otherwise.
REQ-008 SHALL have port wr_strobe  output  1  one-clk pulse when a register write commits.
REQ-009 SHALL have port wr_addr  output  8  sub-address of the committed write; valid with wr_strobe.
REQ-010 SHALL have port wr_data  output  8  data of the committed write; valid with wr_strobe.
REQ-011 SHALL have port busy  output  1  high from a detected START until a STOP or return to IDLE.

Function
REQ-012 SHALL pass sio_c and sio_d through 2-flop synchronizers, then detect edges on the synchronized values.
REQ-013 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-014 SHALL sample SDA on each synchronized SCL rising edge and change its SDA drive on each synchronized SCL falling edge.
REQ-015 SHALL drive or release sio_d within 3 clk cycles of the sio_c falling edge.
REQ-016 SHALL implement states IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE.
REQ-017 Transitions: START in any state -> ID. STOP in any state -> IDLE. After 8 bits in ID: ID[7:1]==CHIP_ADDR[7:1] -> ID_ACK, else -> IGNORE.
REQ-018 ID_ACK SHALL drive SDA low for the 9th bit, then go to SUB when R/W=0 or to RDATA when R/W=1.
REQ-019 After 8 bits SUB -> SUB_ACK, which latches the sub-address and drives ACK low, then -> WDATA.
REQ-020 After 8 bits WDATA -> WDATA_ACK, which drives ACK low, pulses wr_strobe, and writes the register unless the address is 0x0A or 0x0B; then -> IGNORE.
REQ-021 RDATA SHALL shift out reg[latched sub-address] MSB first (0 = drive low, 1 = release), then -> RDATA_NA, which releases SDA, ignores the master's NA/ACK, and goes to IGNORE.
REQ-022 The sub-address SHALL persist across transactions (a 2-phase write followed by a read returns that register); there SHALL be no auto-increment.
REQ-023 The register file SHALL be 256x8, with reads of 0x0A/0x0B returning PID_VAL/VER_VAL.
REQ-024 IGNORE SHALL keep SDA released and wait for START/STOP; a STOP mid-byte SHALL discard the partial byte with no wr_strobe.

Reset
REQ-025 On reset: state=IDLE, SDA released, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, sub-address=0, all registers=0x00, synchronizers loaded with 1.
REQ-026 Reset asserted mid-transaction SHALL release sio_d on the next clk edge and drop any pending write.

Configuration
REQ-027 Macro OV_SCCB_SLAVE_SOFT_RESET_EN, when defined: a committed write to 0x12 with data bit7=1 SHALL start a 256-clk sweep clearing registers 0x00-0xFF to 0x00, with busy held high throughout and the sweep taking priority over concurrent writes (ACKs still driven); 0x12 itself ends at 0x00.
REQ-028 When the macro is undefined, 0x12 SHALL be an ordinary register and no sweep logic SHALL exist.

Verification
REQ-029 3-phase write 0x42,0x3A,0x04 at 100 kHz, clk 25 MHz -> ACK low on all three 9th bits; wr_strobe single pulse with wr_addr=0x3A, wr_data=0x04.
REQ-030 2-phase write 0x42,0x0A, STOP, then read 0x43 -> slave shifts 0x76 MSB first and releases SDA on the 9th bit; an attempted write of 0x55 to 0x0A leaves the read value 0x76.
REQ-031 ID 0x44 then bytes 0x3A,0x04 -> no ACK, sio_d stays high-Z, no wr_strobe, busy falls at STOP.
REQ-032 STOP after 4 data bits of WDATA -> state IDLE, no wr_strobe, and a later read of that sub-address returns its prior value.
REQ-033 With OV_SCCB_SLAVE_SOFT_RESET_EN: write 0x3A=0x04, then 0x12=0x80, then read 0x3A -> 0x00, and busy stays high for at least 256 clk after the write to 0x12 commits.
REQ-034 reset asserted during RDATA while driving low -> sio_d high-Z at the next clk edge and state IDLE.
